key_debounce: RTL
=================

# key_debounce

Multi-channel push-button input conditioner for the board I/O layer: the input-side counterpart of the LED flow driver. It synchronizes raw active-low key inputs into `sys_clk` and debounces each key with its own filter state machine. It presents a clean pressed level plus single-cycle press and release pulses, which feed mode-select and LED-control logic.

## Interface
- `KEY_W`, 8: number of independent key channels.
- `CNT_MAX`, 24'd999_999: debounce hold count, 20 ms at 50 MHz. Legal range 1 to 2^24-1.
- `LONG_MAX`, 24'd14_999_999: long-press threshold in cycles, measured from entry into PRESSED. Used only with `KEY_LONG_PRESS_EN`.

- `sys_clk`, input, 1: system clock, 50 MHz.
- `sys_rst`, input, 1: asynchronous, active-high reset.
- `key_in`, input, KEY_W: raw key pins. Active-low: 0 means pressed. Asynchronous to `sys_clk`.
- `key_state`, output, KEY_W: debounced level per key. 1 means pressed.
- `key_press`, output, KEY_W: one-cycle pulse when a press is accepted.
- `key_release`, output, KEY_W: one-cycle pulse when a release is accepted.
- `key_long`, output, KEY_W: one-cycle pulse when a long press is detected. Constant 0 without the macro.

## Operation
- **Synchronizer:** two-flop chain per bit (`sync1` → `sync2`). Reset value is all 1s, meaning released.
- **Per-key FSM:** each key has an FSM and a 24-bit counter `cnt`. The FSM compares only `sync2`.
- **IDLE** (released)
  - If `sync2`=0: go to PRESS_FILT and set `cnt`=0.
- **PRESS_FILT**
  - If `sync2`=1: go to IDLE and clear `cnt`. No pulse is produced.
  - Else if `cnt`==CNT_MAX: go to PRESSED.
  - Else: `cnt`+1.
- **PRESSED**
  - If `sync2`=1: go to REL_FILT and set `cnt`=0.
- **REL_FILT**
  - If `sync2`=0: go back to PRESSED and clear `cnt`. No pulse is produced.
  - Else if `cnt`==CNT_MAX: go to IDLE.
  - Else: `cnt`+1.
- **Outputs:** all are registered.
  - `key_state`=1 in PRESSED and REL_FILT; 0 in IDLE and PRESS_FILT.
  - `key_press` is high for exactly the one cycle after the PRESS_FILT→PRESSED edge.
  - `key_release` is high for exactly the one cycle after the REL_FILT→IDLE edge.
- **Channel independence:** keys are fully independent. Any combination of keys may press or release on the same cycle, and each gets its own pulse.
- **Counter width:** the counter is 24 bits and is compared with `==`. It never exceeds CNT_MAX, so it cannot wrap.

## Timing
- **Reset values:** `key_state`=0, `key_press`=0, `key_release`=0, `key_long`=0, all FSMs in IDLE, all counters 0, sync flops all 1s.
- **Press latency:** if edge 0 is the first edge that samples `key_in`=0, with the input stable afterwards, then `key_press` and `key_state` rise after edge CNT_MAX+3.
  - `sync2` is low after edge 1.
  - The FSM enters PRESS_FILT at edge 2.
  - `cnt` reaches CNT_MAX at edge CNT_MAX+2.
- **Release latency:** symmetric. `key_release` rises and `key_state` falls after edge CNT_MAX+3.
- **Glitches:** a glitch shorter than CNT_MAX+1 cycles at `sync2` produces no pulse and no change in `key_state`.
- **Reset during operation:** asserting `sys_rst` mid-filter or while pressed forces the reset values immediately, with no release pulse. A key held through reset deassertion is re-detected with full press latency.

## Configuration
- **`KEY_LONG_PRESS_EN` defined:** each key adds a 24-bit `long_cnt`.
  - `long_cnt` is cleared on PRESS_FILT→PRESSED.
  - It increments each cycle in PRESSED and holds in REL_FILT.
  - It saturates at LONG_MAX.
  - When it reaches LONG_MAX, `key_long` pulses for exactly one cycle, once per press.
  - A filtered release glitch (REL_FILT→PRESSED) does not clear `long_cnt` and does not re-arm `key_long`.
- **`KEY_LONG_PRESS_EN` undefined:** no long counter is built, `key_long` is tied to 0, and `LONG_MAX` is ignored.

## Test plan
All scenarios use CNT_MAX=2 and LONG_MAX=6, with `key_in` driven on the negative edge.

1. **Clean press and release:** drive `key_in`[0]=0 and hold it for 20 cycles, then set it to 1.
   - `key_press`[0] pulses for 1 cycle after edge 5 and `key_state`[0] goes to 1.
   - After the return to 1, `key_release`[0] pulses 5 edges later and `key_state`[0] goes to 0.
   - All other bits stay 0.
2. **Bounce rejection:** drive `key_in`[3] low for 2 cycles, then high, 4 times, then hold it low.
   - No pulses occur during the bounce.
   - Exactly one `key_press`[3] occurs, 5 edges after the final fall.
3. **Simultaneous keys:** drive `key_in`=8'h00 on one edge.
   - `key_press`=8'hFF for exactly one cycle and `key_state`=8'hFF.
   - Setting `key_in`=8'hFF gives `key_release`=8'hFF for one cycle.
4. **Reset while pressed:** press key 1, wait until `key_state`[1]=1, pulse `sys_rst` high while the key is still held.
   - All outputs go to 0 immediately with no release pulse.
   - After reset deasserts, `key_press`[1] fires 5 edges later.
5. **Long press (macro on):** hold key 2 for 30 cycles.
   - `key_press`[2] fires first.
   - `key_long`[2] fires once, 6 cycles after entry into PRESSED.
   - No further `key_long` pulses occur.
   - With the macro off, `key_long` stays 8'h00 throughout.
6. **Release glitch:** while key 4 is pressed, drive 1 for 2 cycles, then 0.
   - No `key_release` occurs and `key_state`[4] stays 1.

Source files
------------

// File: rtl/key_debounce.sv
// Synchronizes active-low key pins and debounces each one with its own filter FSM.
// Optional long-press pulse per key is built when KEY_LONG_PRESS_EN is defined.
module key_debounce #(
  parameter int          KEY_W    = 8,
  parameter logic [23:0] CNT_MAX  = 24'd999_999,
  parameter logic [23:0] LONG_MAX = 24'd14_999_999
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic [KEY_W-1:0] key_in,
  output logic [KEY_W-1:0] key_state,
  output logic [KEY_W-1:0] key_press,
  output logic [KEY_W-1:0] key_release,
  output logic [KEY_W-1:0] key_long
);

  localparam logic [1:0] IDLE       = 2'd0;
  localparam logic [1:0] PRESS_FILT = 2'd1;
  localparam logic [1:0] PRESSED    = 2'd2;
  localparam logic [1:0] REL_FILT   = 2'd3;

  logic [KEY_W-1:0] sync1;
  logic [KEY_W-1:0] sync2;

  // Reset to all ones so every key starts out released.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      sync1 <= '1;
      sync2 <= '1;
    end else begin
      sync1 <= key_in;
      sync2 <= sync1;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < KEY_W; gi++) begin : g_key
      logic [1:0]  state_reg, state_next;
      logic [23:0] cnt_reg, cnt_next;
      logic        level_reg, press_reg, release_reg;

      always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
          IDLE: begin
            if (!sync2[gi]) begin
              state_next = PRESS_FILT;
              cnt_next   = '0;
            end
          end
          PRESS_FILT: begin
            if (sync2[gi]) begin
              state_next = IDLE;
              cnt_next   = '0;
            end else if (cnt_reg == CNT_MAX) begin
              state_next = PRESSED;
              cnt_next   = '0;
            end else begin
              cnt_next = cnt_reg + 24'd1;
            end
          end
          PRESSED: begin
            if (sync2[gi]) begin
              state_next = REL_FILT;
              cnt_next   = '0;
            end
          end
          default: begin
            if (!sync2[gi]) begin
              state_next = PRESSED;
              cnt_next   = '0;
            end else if (cnt_reg == CNT_MAX) begin
              state_next = IDLE;
              cnt_next   = '0;
            end else begin
              cnt_next = cnt_reg + 24'd1;
            end
          end
        endcase
      end

      // Outputs are derived from the next state so they line up with the state change.
      always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
          state_reg   <= IDLE;
          cnt_reg     <= '0;
          level_reg   <= 1'b0;
          press_reg   <= 1'b0;
          release_reg <= 1'b0;
        end else begin
          state_reg   <= state_next;
          cnt_reg     <= cnt_next;
          level_reg   <= (state_next == PRESSED) || (state_next == REL_FILT);
          press_reg   <= (state_reg == PRESS_FILT) && (state_next == PRESSED);
          release_reg <= (state_reg == REL_FILT) && (state_next == IDLE);
        end
      end

      assign key_state[gi]   = level_reg;
      assign key_press[gi]   = press_reg;
      assign key_release[gi] = release_reg;

`ifdef KEY_LONG_PRESS_EN
      logic [23:0] long_cnt_reg, long_cnt_next;
      logic        long_hit;
      logic        long_reg;

      // Saturation at LONG_MAX is what keeps the pulse to once per accepted press.
      always_comb begin
        long_cnt_next = long_cnt_reg;
        long_hit      = 1'b0;
        if ((state_reg == PRESS_FILT) && (state_next == PRESSED)) begin
          long_cnt_next = '0;
        end else if ((state_reg == PRESSED) && (long_cnt_reg != LONG_MAX)) begin
          long_cnt_next = long_cnt_reg + 24'd1;
          long_hit      = (long_cnt_next == LONG_MAX);
        end
      end

      always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
          long_cnt_reg <= '0;
          long_reg     <= 1'b0;
        end else begin
          long_cnt_reg <= long_cnt_next;
          long_reg     <= long_hit;
        end
      end

      assign key_long[gi] = long_reg;
`else
      assign key_long[gi] = 1'b0;
`endif
    end
  endgenerate

`ifndef KEY_LONG_PRESS_EN
  logic [23:0] long_max_unused;
  assign long_max_unused = LONG_MAX;
`endif

endmodule
